// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
// The defaults reproduce the original 100 MHz to 5 kHz divider.
package clk_div_pkg;

  localparam int unsigned DefaultCntW = 16;
  localparam int unsigned DefaultDiv  = 20000;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active/pending divisor and registered
// clock/tick outputs. Divisor changes only take effect at a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic             sync_i,
  output logic             pending_o,
  output logic             clk_o,
  output logic             tick_o
);

  localparam logic [CNT_W-1:0] DivRst = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pv_q, pv_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             running, wrap, apply;

  always_comb begin
    running = en_i && (div_q != '0);
    wrap    = running && (cnt_q == div_q - One);
    apply   = pv_q && (wrap || !running || sync_i);
    div_d   = apply ? pend_q : div_q;
    // A write on the apply edge still lands in pend and keeps it valid.
    pend_d  = wr_i ? div_i : pend_q;
    pv_d    = wr_i | (pv_q & ~apply);

    cnt_d  = cnt_q;
    clk_d  = 1'b0;
    tick_d = 1'b0;
    if (!en_i) begin
      // Parked one short of wrap so re-enable starts a period immediately.
      cnt_d = div_d - One;
    end else if (sync_i) begin
      if (div_d != '0) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        clk_d  = (div_d >> 1) != '0;
      end
    end else if (running) begin
      cnt_d  = wrap ? '0 : cnt_q + One;
      tick_d = (cnt_d == '0);
      clk_d  = cnt_d < (div_d >> 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= DivRst;
      pend_q <= '0;
      pv_q   <= 1'b0;
      cnt_q  <= DivRst - One;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      pend_q <= pend_d;
      pv_q   <= pv_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign pending_o = pv_q;
  assign clk_o     = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/enable divider. Decodes divisor writes to
// per-channel strobes and broadcasts the phase-align pulse.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic                          CLK100MHZ,
  input  logic                          CPU_RESETN,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          cfg_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]              cfg_div,
  input  logic                          sync_all,
  output logic [NUM_CH-1:0]             upd_pending,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             tick
);

  localparam int unsigned ChW = ch_idx_w(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr;
    // Out-of-range channel indices match no channel and are dropped.
    assign wr = cfg_wr && (cfg_ch == ChW'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (CLK100MHZ),
      .rst_ni    (CPU_RESETN),
      .en_i      (en[i]),
      .wr_i      (wr),
      .div_i     (cfg_div),
      .sync_i    (sync_all),
      .pending_o (upd_pending[i]),
      .clk_o     (clk_out[i]),
      .tick_o    (tick[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the single fixed 100 MHz→5 kHz divider.
- N independent channels, each with:
  - a runtime-programmable integer divisor;
  - a square clock-like output;
  - a single-cycle tick enable.
- Divisor updates are glitch-free: applied only at a period boundary.
- A global sync pulse phase-aligns all channels.
- Sits next to the board clock and feeds sensor-sampling logic (accelerometer SPI, display refresh) with enables, not derived clocks.

Parameters:
- NUM_CH, 2, number of divider channels.
- CNT_W, 16, counter and divisor width in bits.
- DEFAULT_DIV, 20000, divisor loaded at reset in every channel (100 MHz / 20000 = 5 kHz).

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESETN  input  1  asynchronous, active-low reset.
- en  input  NUM_CH  per-channel run enable.
- cfg_wr  input  1  one-cycle divisor write strobe.
- cfg_ch  input  clog2(NUM_CH) (min 1)  target channel of the write.
- cfg_div  input  CNT_W  new divisor D.
- sync_all  input  1  one-cycle strobe that restarts every channel's period.
- upd_pending  output  NUM_CH  divisor written but not yet applied.
- clk_out  output  NUM_CH  divided square wave, registered.
- tick  output  NUM_CH  one-cycle pulse at each period start, registered.

Behaviour:
- Per channel: active divisor div_q, pending divisor pend_q with valid bit pv, counter cnt (CNT_W).
- Reset (CPU_RESETN=0, async):
  - div_q = DEFAULT_DIV, pv = 0, cnt = DEFAULT_DIV-1.
  - clk_out = 0, tick = 0, upd_pending = 0.
- Run (en=1, D = div_q ≥ 1):
  - cnt = (cnt == D-1) ? 0 : cnt+1.
  - Registered outputs follow the next cnt value:
    - clk_out = (cnt_next < D>>1);
    - tick = (cnt_next == 0).
  - Result: period D cycles; high phase floor(D/2) cycles, low phase ceil(D/2) cycles.
  - The first tick and clk_out rising edge occur on the first clock edge after reset release.
- D = 1: tick high every cycle, clk_out stays 0.
- D = 0: channel halted; cnt holds, clk_out = 0, tick = 0.
- en = 0: cnt forced to D-1, clk_out = 0, tick = 0. On re-enable, the next edge gives cnt = 0 and tick = 1.
- Write (cfg_wr=1): pend_q[cfg_ch] = cfg_div, pv = 1. cfg_ch ≥ NUM_CH is ignored.
- Apply: div_q = pend_q and pv cleared on the edge where:
  - the channel wraps (cnt == D-1 while running), or
  - the channel is disabled or halted (en=0 or D=0), or
  - sync_all = 1.
- Applied-divisor timing: the wrap edge still produces tick = 1, and the new period uses the new D from cnt = 0.
- Write on the same edge as an apply for that channel: the write wins. The new value goes to pend_q, pv stays 1, and the old pend_q is applied. Last write before the boundary is the one used.
- sync_all = 1: every enabled channel with D ≥ 1 loads cnt = 0, tick = 1, clk_out = (0 < D>>1), applying any pending divisor first. Disabled channels ignore it except for applying pending.
- upd_pending = pv (registered).
- Mid-operation reset: immediate async return to reset values, and pending writes are lost.
- No combinational path from inputs to outputs.

Decomposition:
- Package clk_div_pkg: CNT_W default, DEFAULT_DIV, helper constant for the channel-index width.
- Natural sub-module: clk_div_chan, one channel (counter, div/pend regs, output regs).
- Top instantiates NUM_CH copies and decodes cfg_ch into per-channel write strobes.

Test Plan:
- Reset release with defaults → both channels tick on the first edge, then every 20000 cycles; clk_out high for 10000 cycles, low for 10000.
- ch0 set to D=5 → tick period 5, clk_out high 2 / low 3; upd_pending[0] high from the write until the ch0 wrap edge, and no short or long period at the switch.
- Two writes to ch1 (D=7, then D=9) before the boundary → only 9 is applied, with upd_pending high throughout.
- D=1 → tick constantly 1 and clk_out 0; D=0 → both 0 and cnt frozen.
- ch0 D=4, ch1 D=6 out of phase, then sync_all → both tick on the same next edge and realign every 12 cycles.
- CPU_RESETN asserted mid-period with a pending write → outputs 0 immediately, div back to 20000, upd_pending cleared; en=0 then 1 → tick on the first re-enabled edge.
